// File: rtl/mux_structural_pkg.sv
// ============================================================================
// Module  : mux_structural_pkg
// Brief   : Select-field sizing shared by the structural 4:1 mux and its decoder
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_structural_pkg;

  // Two select bits {s1,s0}. They decode to one AND plane per data input.
  localparam int c_sel_w  = 2;
  localparam int c_num_in = 1 << c_sel_w;

endpackage

`default_nettype wire

// File: rtl/mux_structural_dec2to4.sv
// ============================================================================
// Module  : mux_dec2to4
// Brief   : Gate-level 2-to-4 one-hot decoder; sel[k] is high when {s1,s0}==k
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_dec2to4
  import mux_structural_pkg::*;
(
  input  logic                s1,
  input  logic                s0,
  output logic [c_num_in-1:0] sel
);

  wire w_s0_n;
  wire w_s1_n;

  not u_inv_s0 (w_s0_n, s0);
  not u_inv_s1 (w_s1_n, s1);

  and u_and_sel0 (sel[0], w_s1_n, w_s0_n);
  and u_and_sel1 (sel[1], w_s1_n, s0);
  and u_and_sel2 (sel[2], s1,     w_s0_n);
  and u_and_sel3 (sel[3], s1,     s0);

endmodule

`default_nettype wire

// File: rtl/mux_structural.sv
// ============================================================================
// Module  : mux_structural
// Brief   : Structural 4:1 mux (decoder + AND/OR planes) with a registered copy
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_structural
  import mux_structural_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_q
);

  logic [c_num_in-1:0] w_sel;
  logic [WIDTH-1:0]    w_d;
  logic [WIDTH-1:0]    r_d_q;

  mux_dec2to4 u_dec (
    .s1  (s1),
    .s0  (s0),
    .sel (w_sel)
  );

  // Each output bit is an independent AND-OR slice gated by the one-hot selects.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    wire w_p0;
    wire w_p1;
    wire w_p2;
    wire w_p3;

    and u_and_p0 (w_p0, w_sel[0], i0[b]);
    and u_and_p1 (w_p1, w_sel[1], i1[b]);
    and u_and_p2 (w_p2, w_sel[2], i2[b]);
    and u_and_p3 (w_p3, w_sel[3], i3[b]);
    or  u_or     (w_d[b], w_p0, w_p1, w_p2, w_p3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q <= '0;
    end else begin
      r_d_q <= w_d;
    end
  end

  assign d   = w_d;
  assign d_q = r_d_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_structural.sv
// ============================================================================
// Module  : tb_mux_structural
// Brief   : Self-checking bench for mux_structural (WIDTH=4) with a reference model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_structural;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] i0, i1, i2, i3;
  logic             s0, s1;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_q;

  int n_cmp;
  int n_err;

  mux_structural #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .s0    (s0),
    .s1    (s1),
    .d     (d),
    .d_q   (d_q)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: pick the input whose index equals the select value.
  function automatic logic [WIDTH-1:0] ref_mux(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] a, b, c, e);
    logic [WIDTH-1:0] tbl [4];
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = e;
    return tbl[sel];
  endfunction

  task automatic drive(input logic [1:0] sel, input logic [WIDTH-1:0] a, b, c, e);
    {s1, s0} = sel;
    i0 = a; i1 = b; i2 = c; i3 = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b10, 4'h0, 4'h0, 4'h9, 4'h0);
    #1;
    n_cmp++;
    if (d_q !== 4'h0) begin n_err++; $display("FAIL reset_dq: got %h want %h", d_q, 4'h0); end
    @(posedge clk); #1;
    n_cmp++;
    if (d_q !== 4'h0) begin n_err++; $display("FAIL reset_hold_dq: got %h want %h", d_q, 4'h0); end
    n_cmp++;
    if (d !== 4'h9) begin n_err++; $display("FAIL reset_d_tracks: got %h want %h", d, 4'h9); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_inputs();
    for (int k = 0; k < 4; k++) begin
      drive(k[1:0], 4'h0, 4'h0, 4'h0, 4'h0);
      #2;
      n_cmp++;
      if (d !== 4'h0) begin n_err++; $display("FAIL zero_sel%0d: got %h want %h", k, d, 4'h0); end
    end
  endtask

  task automatic test_one_hot();
    logic [WIDTH-1:0] v [4];
    logic [WIDTH-1:0] exp;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) v[j] = (j == k) ? 4'h1 : 4'h0;
      drive(k[1:0], v[0], v[1], v[2], v[3]);
      exp = ref_mux(k[1:0], v[0], v[1], v[2], v[3]);
      #2;
      n_cmp++;
      if (d !== exp) begin n_err++; $display("FAIL onehot_sel%0d: got %h want %h", k, d, exp); end
    end
  endtask

  task automatic test_isolation();
    for (int m = 0; m < 8; m++) begin
      drive(2'b01, {4{m[0]}}, 4'h0, {4{m[1]}}, {4{m[2]}});
      #2;
      n_cmp++;
      if (d !== 4'h0) begin n_err++; $display("FAIL isolation_%0d: got %h want %h", m, d, 4'h0); end
    end
    i1 = 4'hF;
    #2;
    n_cmp++;
    if (d !== 4'hF) begin n_err++; $display("FAIL isolation_sel: got %h want %h", d, 4'hF); end
  endtask

  task automatic test_register_latency();
    @(negedge clk);
    drive(2'b10, 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk); #4;
    i2 = 4'hF;
    #1;
    n_cmp++;
    if (d !== 4'hF) begin n_err++; $display("FAIL latency_d: got %h want %h", d, 4'hF); end
    n_cmp++;
    if (d_q !== 4'h0) begin n_err++; $display("FAIL latency_dq_early: got %h want %h", d_q, 4'h0); end
    @(posedge clk); #1;
    n_cmp++;
    if (d_q !== 4'hF) begin n_err++; $display("FAIL latency_dq: got %h want %h", d_q, 4'hF); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(2'b10, 4'h0, 4'h0, 4'hF, 4'h0);
    @(posedge clk); #1;
    n_cmp++;
    if (d_q !== 4'hF) begin n_err++; $display("FAIL async_pre: got %h want %h", d_q, 4'hF); end
    #4;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (d_q !== 4'h0) begin n_err++; $display("FAIL async_clear: got %h want %h", d_q, 4'h0); end
    n_cmp++;
    if (d !== 4'hF) begin n_err++; $display("FAIL async_d: got %h want %h", d, 4'hF); end
    @(posedge clk); #1;
    n_cmp++;
    if (d_q !== 4'h0) begin n_err++; $display("FAIL async_hold: got %h want %h", d_q, 4'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (d_q !== 4'h0) begin n_err++; $display("FAIL async_release: got %h want %h", d_q, 4'h0); end
    @(posedge clk); #1;
    n_cmp++;
    if (d_q !== 4'hF) begin n_err++; $display("FAIL async_reload: got %h want %h", d_q, 4'hF); end
  endtask

  task automatic test_pattern_sweep();
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] prev;
    prev = 'x;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(k[1:0], 4'hA, 4'h5, 4'hC, 4'h3);
      exp = ref_mux(k[1:0], 4'hA, 4'h5, 4'hC, 4'h3);
      #2;
      n_cmp++;
      if (d !== exp) begin n_err++; $display("FAIL sweep_d_sel%0d: got %h want %h", k, d, exp); end
      if (k > 0) begin
        n_cmp++;
        if (d_q !== prev) begin n_err++; $display("FAIL sweep_dq_before_sel%0d: got %h want %h", k, d_q, prev); end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== exp) begin n_err++; $display("FAIL sweep_dq_sel%0d: got %h want %h", k, d_q, exp); end
      prev = exp;
    end
  endtask

  task automatic test_random();
    logic [1:0]       sel;
    logic [WIDTH-1:0] a, b, c, e, exp;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      sel = 2'($urandom_range(0, 3));
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      c = WIDTH'($urandom); e = WIDTH'($urandom);
      drive(sel, a, b, c, e);
      exp = ref_mux(sel, a, b, c, e);
      #2;
      n_cmp++;
      if (d !== exp) begin n_err++; $display("FAIL rand_d_%0d: got %h want %h", n, d, exp); end
      @(posedge clk); #1;
      n_cmp++;
      if (d_q !== exp) begin n_err++; $display("FAIL rand_dq_%0d: got %h want %h", n, d_q, exp); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_zero_inputs();
    test_one_hot();
    test_isolation();
    test_register_latency();
    test_async_reset();
    test_pattern_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
